// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin owner of the shared 4:1 mux, drives sel0/sel1.
// Define MUX_ARB_TIMEOUT_EN to compile in the hold limit and timeout pulse.
module mux4_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       sel0,
    output logic       sel1,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    state_t     state;
    logic [1:0] last;
    logic [1:0] win;

`ifdef MUX_ARB_TIMEOUT_EN
    logic [CW-1:0] cnt;
`else
    logic unused_hold;
    assign unused_hold = ^HOLD_MAX;
    assign timeout     = 1'b0;
`endif

    // Round-robin pick: first set req after the previous owner, wrapping,
    // so the owner that just finished is always considered last.
    always_comb begin
        win = last;
        for (int i = 4; i >= 1; i--) begin
            if (req[last + 2'(i)]) begin
                win = last + 2'(i);
            end
        end
    end

    // Grant sequencer: IDLE/GAP arbitrate, GRANT holds until release/limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            last  <= 2'd3;
            gnt   <= 4'b0000;
            sel0  <= 1'b0;
            sel1  <= 1'b0;
            busy  <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt     <= '0;
            timeout <= 1'b0;
`endif
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            unique case (state)
                IDLE, GAP: begin
                    if (|req) begin
                        state <= GRANT;
                        last  <= win;
                        gnt   <= 4'b0001 << win;
                        sel0  <= win[1];
                        sel1  <= win[0];
                        busy  <= 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
                        cnt   <= CW'(1);
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    // The owner is always the most recent winner.
                    if (!req[last]) begin
                        state <= GAP;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                    end
`ifdef MUX_ARB_TIMEOUT_EN
                    else if (cnt == HOLD_MAX) begin
                        state   <= GAP;
                        gnt     <= 4'b0000;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter: directed vectors plus a cycle model of the arbiter.
// Expectations follow MUX_ARB_TIMEOUT_EN when it is defined.
module tb_mux4_arbiter;

    localparam int MAXH = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       sel0;
    logic       sel1;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    mux4_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt),
        .sel0    (sel0),
        .sel1    (sel1),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Model: owner index (-1 = nobody), how long it has held, last winner.
    int m_own  = -1;
    int m_last = 3;
    int m_held = 0;
    int m_sel  = 0;
    bit m_to   = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_own  = -1;
            m_last = 3;
            m_held = 0;
            m_sel  = 0;
            m_to   = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_own >= 0) begin
                if (!req[m_own]) begin
                    m_own = -1;
                end else if (TO_EN && m_held >= MAXH) begin
                    m_own = -1;
                    m_to  = 1'b1;
                end else begin
                    m_held = m_held + 1;
                end
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    if (m_own < 0 && req[(m_last + k) % 4]) begin
                        m_own = (m_last + k) % 4;
                    end
                end
                if (m_own >= 0) begin
                    m_last = m_own;
                    m_sel  = m_own;
                    m_held = 1;
                end
            end
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        logic [7:0] got;
        logic [7:0] exp;
        logic [3:0] eg;
        #1;
        eg  = (m_own >= 0) ? 4'(1 << m_own) : 4'b0000;
        got = {gnt, sel0, sel1, busy, timeout};
        exp = {eg, 2'(m_sel), m_own >= 0, m_to};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL model t=%0t got %b exp %b", $time, got, exp);
        end
    end

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", nm, got, exp);
        end
    endtask

    // Drive req for one edge, then check {gnt,sel,busy,timeout}.
    task automatic run_vec(input string nm, input logic [3:0] r,
                           input logic [3:0] eg, input logic [1:0] es,
                           input logic et);
        req = r;
        @(negedge clk);
        chk(nm, {gnt, sel0, sel1, busy, timeout}, {eg, es, |eg, et});
    endtask

    task automatic do_reset();
        req     = 4'b0000;
        reset_n = 1'b0;
        #1;
        chk("reset", {gnt, sel0, sel1, busy, timeout}, 8'b0000_00_0_0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        chk("por", {gnt, sel0, sel1, busy, timeout}, 8'b0000_00_0_0);
        reset_n = 1'b1;

        // Two requesters, each releasing after three grant cycles.
        do_reset();
        run_vec("s1_g0a", 4'b0101, 4'b0001, 2'b00, 1'b0);
        run_vec("s1_g0b", 4'b0101, 4'b0001, 2'b00, 1'b0);
        run_vec("s1_g0c", 4'b0101, 4'b0001, 2'b00, 1'b0);
        run_vec("s1_gap1", 4'b0100, 4'b0000, 2'b00, 1'b0);
        run_vec("s1_g2a", 4'b0101, 4'b0100, 2'b10, 1'b0);
        run_vec("s1_g2b", 4'b0101, 4'b0100, 2'b10, 1'b0);
        run_vec("s1_g2c", 4'b0101, 4'b0100, 2'b10, 1'b0);
        run_vec("s1_gap2", 4'b0001, 4'b0000, 2'b10, 1'b0);
        run_vec("s1_g0d", 4'b0101, 4'b0001, 2'b00, 1'b0);
        run_vec("s1_g0e", 4'b0101, 4'b0001, 2'b00, 1'b0);
        run_vec("s1_g0f", 4'b0101, 4'b0001, 2'b00, 1'b0);
        run_vec("s1_gap3", 4'b0000, 4'b0000, 2'b00, 1'b0);
        run_vec("s1_idle", 4'b0000, 4'b0000, 2'b00, 1'b0);

        // All four requesting, one-cycle grants, wrap back to 0.
        do_reset();
        run_vec("s2_g0", 4'b1111, 4'b0001, 2'b00, 1'b0);
        run_vec("s2_p0", 4'b1110, 4'b0000, 2'b00, 1'b0);
        run_vec("s2_g1", 4'b1111, 4'b0010, 2'b01, 1'b0);
        run_vec("s2_p1", 4'b1101, 4'b0000, 2'b01, 1'b0);
        run_vec("s2_g2", 4'b1111, 4'b0100, 2'b10, 1'b0);
        run_vec("s2_p2", 4'b1011, 4'b0000, 2'b10, 1'b0);
        run_vec("s2_g3", 4'b1111, 4'b1000, 2'b11, 1'b0);
        run_vec("s2_p3", 4'b0111, 4'b0000, 2'b11, 1'b0);
        run_vec("s2_g0w", 4'b1111, 4'b0001, 2'b00, 1'b0);
        run_vec("s2_p0w", 4'b1110, 4'b0000, 2'b00, 1'b0);
        run_vec("s2_idle", 4'b0000, 4'b0000, 2'b00, 1'b0);

        // Continuous single requester: limited to MAXH cycles if enabled.
        do_reset();
        for (int i = 0; i < (TO_EN ? 11 : 50); i++) begin
            if (TO_EN && (i % 5) == 4)
                run_vec("s3_gap", 4'b0010, 4'b0000, 2'b01, 1'b1);
            else
                run_vec("s3_hold", 4'b0010, 4'b0010, 2'b01, 1'b0);
        end
        run_vec("s3_rel", 4'b0000, 4'b0000, 2'b01, 1'b0);

        // Reset during the second grant cycle, then restart at priority 0.
        do_reset();
        run_vec("s4_g3a", 4'b1000, 4'b1000, 2'b11, 1'b0);
        run_vec("s4_g3b", 4'b1000, 4'b1000, 2'b11, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("s4_async", {gnt, sel0, sel1, busy, timeout}, 8'b0000_00_0_0);
        req = 4'b1001;
        @(negedge clk);
        reset_n = 1'b1;
        run_vec("s4_g0", 4'b1001, 4'b0001, 2'b00, 1'b0);
        run_vec("s4_rel", 4'b0000, 4'b0000, 2'b00, 1'b0);

        // Release on the same edge the hold limit is reached.
        do_reset();
        run_vec("s5_g0a", 4'b0101, 4'b0001, 2'b00, 1'b0);
        run_vec("s5_g0b", 4'b0101, 4'b0001, 2'b00, 1'b0);
        run_vec("s5_g0c", 4'b0101, 4'b0001, 2'b00, 1'b0);
        run_vec("s5_g0d", 4'b0101, 4'b0001, 2'b00, 1'b0);
        run_vec("s5_gap", 4'b0100, 4'b0000, 2'b00, 1'b0);
        run_vec("s5_g2", 4'b0100, 4'b0100, 2'b10, 1'b0);
        run_vec("s5_rel", 4'b0000, 4'b0000, 2'b10, 1'b0);

        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter and sequencer for the shared `mux4_1` datapath. Four requesters (e.g. player-input, drop-animation, win-check and display-refresh paths) compete for the single 4:1 mux. The block grants one requester at a time and drives the mux select lines `sel0`/`sel1`. It holds each grant until the requester releases it, or until a hold limit expires, and inserts a one-cycle turnaround between owners.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester may own the mux; legal range 1..255.
- `CW`, default `$clog2(MAX_HOLD+1)`: hold-counter width; derived, not overridden.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request vector; bit k = requester k wants mux input `ik`.
- `gnt`  out  4  one-hot grant, registered; all-zero when nobody owns the mux.
- `sel0`  out  1  mux select MSB, registered; chooses pair {i0,i1} (0) vs {i2,i3} (1).
- `sel1`  out  1  mux select LSB, registered; chooses within the pair.
- `busy`  out  1  high while in GRANT.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- Selected mux input index = {sel0,sel1}: i0=00, i1=01, i2=10, i3=11. Whenever gnt[k]=1, {sel0,sel1}=k.
- States:
  - IDLE: gnt=0.
    - If any req bit is set, go to GRANT with the round-robin winner.
    - Otherwise stay in IDLE.
  - GRANT: gnt=onehot(owner), busy=1, hold counter increments each cycle.
    - If req[owner]=0, go to GAP.
    - If the counter reaches MAX_HOLD while req[owner]=1, go to GAP with timeout=1. This case applies only when the macro is defined (see Configuration).
  - GAP: gnt=0, busy=0. Arbitration happens in this state.
    - If any req bit is set, go to GRANT with the new winner.
    - Otherwise go to IDLE.
- Round-robin rule:
  - Search starts at (last+1) mod 4 and wraps. The first set req bit wins.
  - `last` updates on every grant.
  - A requester whose grant just ended has the lowest priority in the next arbitration, but may win again if it is the only requester.
- The hold counter loads 1 on entry to GRANT and saturates at MAX_HOLD.
- sel0/sel1 keep their last value while in IDLE or GAP. The mux output is don't-care when gnt=0.
- req bits other than the owner's are ignored in GRANT. A change of req[owner] is evaluated only in GRANT.

## Timing
- Reset (reset_n=0, effective immediately):
  - gnt=0000, sel0=0, sel1=0, busy=0, timeout=0.
  - State=IDLE, last=3, so requester 0 has the highest priority first. Hold counter=0.
- Grant latency: req sampled high in IDLE at edge N → gnt, sel and busy valid after edge N.
- Release: req[owner] low at edge N → gnt=0 after edge N (GAP). The next grant appears after edge N+1. Minimum turnaround is one cycle with gnt=0.
- Maximum ownership is exactly MAX_HOLD cycles of gnt high. timeout is high during the first GAP cycle only.
- Simultaneous events:
  - Release and counter reaching MAX_HOLD on the same edge count as a normal release; timeout stays 0.
  - New requests arriving during GAP are included in that GAP's arbitration.
- Reset asserted mid-grant: gnt drops asynchronously with no GAP cycle. After reset, arbitration restarts at priority 0.
- MAX_HOLD=1 gives a one-cycle grant and a one-cycle gap, alternating, under continuous requests.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - The hold counter and forced release are compiled in.
  - `timeout` pulses as described above.
- `MUX_ARB_TIMEOUT_EN` not defined:
  - The counter logic is absent, and a grant is held until req[owner] drops, with no upper bound.
  - `timeout` is tied to 0.
  - `MAX_HOLD` is accepted but unused.

## Test plan
- Reset, then req=0101 held steady with the owner releasing after 3 cycles of gnt:
  - Grants run 0001 → 0100 → 0001, each 3 cycles long with a 1-cycle gnt=0 gap between them.
  - {sel0,sel1} reads 00, 10, 00 during the respective grants.
- req=1111 with every owner releasing after 1 cycle:
  - Grant order is 0, 1, 2, 3, 0 (wrap).
  - sel steps through 00, 01, 10, 11, 00.
- Macro defined, MAX_HOLD=4, req=0010 held high continuously:
  - gnt=0010 for exactly 4 cycles, then 1 cycle of gnt=0 with timeout=1, then gnt=0010 again.
- Macro undefined, same stimulus as the previous scenario: gnt=0010 for 50 cycles with no gap, and timeout stays 0.
- req=1000 and reset_n pulsed low during the 2nd grant cycle:
  - gnt=0000 and sel=00 immediately.
  - After reset_n returns high with req=1001, requester 0 wins first.
- Owner drops req on the same edge its counter reaches MAX_HOLD, while req[2] is also high:
  - timeout stays 0, followed by 1 gap cycle, then gnt=0100.
